// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw-input source and the debounce_sync conditioning stage.
// The source side drives din/en; the debouncer drives the conditioned level and strobes.
interface debounce_sync_if;
  logic din;
  logic en;
  logic q;
  logic qn;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, en, input q, qn, rise, fall, busy);
  modport slave  (input din, en, output q, qn, rise, fall, busy);
endinterface

// File: rtl/debounce_sync.sv
// Synchronises an asynchronous level into clk, accepts a new level only after it has been
// stable for STABLE_CNT en ticks, and strobes rise/fall for one cycle on each accepted change.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = 1000
) (
    input logic           clk,
    input logic           resn,
    debounce_sync_if.slave bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be 2..4");
    end
    if (STABLE_CNT < 1 || longint'(STABLE_CNT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt
        $error("debounce_sync: STABLE_CNT must be 1..2**CNT_W-1");
    end

    typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   ds;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   q_r, qn_r, rise_r, fall_r;

    assign ds = sync[SYNC_STAGES-1];

    // NOTE: all state below updates with non-blocking assignments so every flop samples
    // pre-edge values; the sync chain shift depends on that to delay one stage per clock.
    always_ff @(posedge clk) begin
        if (!resn) begin
            sync   <= '0;
            state  <= LOW;
            cnt    <= '0;
            q_r    <= 1'b0;
            qn_r   <= 1'b1;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], bus.din};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            // The glitch test is evaluated before qualification in both check states.
            case (state)
                LOW: begin
                    if (ds) begin
                        state <= CHK_H;
                        cnt   <= '0;
                    end
                end
                CHK_H: begin
                    if (!ds) begin
                        state <= LOW;
                    end else if (bus.en && cnt == LAST) begin
                        state  <= HIGH;
                        q_r    <= 1'b1;
                        qn_r   <= 1'b0;
                        rise_r <= 1'b1;
                    end else if (bus.en) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!ds) begin
                        state <= CHK_L;
                        cnt   <= '0;
                    end
                end
                CHK_L: begin
                    if (ds) begin
                        state <= HIGH;
                    end else if (bus.en && cnt == LAST) begin
                        state  <= LOW;
                        q_r    <= 1'b0;
                        qn_r   <= 1'b1;
                        fall_r <= 1'b1;
                    end else if (bus.en) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.qn   = qn_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.busy = (state == CHK_H) || (state == CHK_L);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync (SYNC_STAGES=2, STABLE_CNT=4): a driver queues the
// hand-computed post-edge outputs per cycle and a negedge monitor pops and compares them.
module tb_debounce_sync;

    logic clk;
    logic resn;

    debounce_sync_if bus ();

    debounce_sync #(
        .SYNC_STAGES(2),
        .CNT_W      (16),
        .STABLE_CNT (4)
    ) dut (
        .clk (clk),
        .resn(resn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after an edge, packed as {q, rise, fall, busy}; qn is always ~q.
    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got {q,qn,rise,fall,busy}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, {bus.q, bus.qn, bus.rise, bus.fall, bus.busy},
                  {e.exp[3], ~e.exp[3], e.exp[2:0]});
        end
    end

    // One clock of stimulus; the response to the following posedge is queued for the monitor.
    task automatic drive(input string name, input logic r, input logic d, input logic e,
                         input logic [3:0] exp);
        exp_t x;
        @(negedge clk);
        #1;
        resn    = r;
        bus.din = d;
        bus.en  = e;
        x.name  = name;
        x.exp   = exp;
        sb.push_back(x);
    endtask

    task automatic seg(input string name, input logic r, input logic d, input int n,
                       input logic [3:0] exp);
        for (int i = 0; i < n; i++) drive(name, r, d, 1'b1, exp);
    endtask

    // Held 0->1 with en=1: two sync edges, four qualifying edges, accept at edge 7.
    task automatic rise_seq(input string name);
        seg(name, 1'b1, 1'b1, 2, 4'b0000);
        seg(name, 1'b1, 1'b1, 4, 4'b0001);
        seg(name, 1'b1, 1'b1, 1, 4'b1100);
        seg(name, 1'b1, 1'b1, 1, 4'b1000);
    endtask

    task automatic fall_seq(input string name);
        seg(name, 1'b1, 1'b0, 2, 4'b1000);
        seg(name, 1'b1, 1'b0, 4, 4'b1001);
        seg(name, 1'b1, 1'b0, 1, 4'b0010);
        seg(name, 1'b1, 1'b0, 1, 4'b0000);
    endtask

    initial begin
        resn    = 1'b0;
        bus.din = 1'b1;
        bus.en  = 1'b1;

        // 1. Reset held with din=1, then release: q=1 at the 7th edge.
        seg("reset", 1'b0, 1'b1, 3, 4'b0000);
        rise_seq("reset_release");

        // 5. Falling edge from q=1.
        fall_seq("fall");

        // 2. Clean step.
        rise_seq("clean_rise");
        fall_seq("clean_fall");

        // 3. Glitch: din=1 for 3 cycles then 0.
        seg("glitch3", 1'b1, 1'b1, 2, 4'b0000);
        seg("glitch3", 1'b1, 1'b1, 1, 4'b0001);
        seg("glitch3", 1'b1, 1'b0, 2, 4'b0001);
        seg("glitch3", 1'b1, 1'b0, 3, 4'b0000);

        // Boundary: ds drops on the very edge the count would complete -> rejected.
        seg("glitch_at_done", 1'b1, 1'b1, 2, 4'b0000);
        seg("glitch_at_done", 1'b1, 1'b1, 2, 4'b0001);
        seg("glitch_at_done", 1'b1, 1'b0, 2, 4'b0001);
        seg("glitch_at_done", 1'b1, 1'b0, 3, 4'b0000);

        // 4. en on every 3rd edge: ticks in CHK_H at edges 6,9,12,15 -> accept at edge 15.
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] e;
            if (k <= 2)       e = 4'b0000;
            else if (k <= 14) e = 4'b0001;
            else if (k == 15) e = 4'b1100;
            else              e = 4'b1000;
            drive("en_throttle", 1'b1, 1'b1, (k % 3) == 0, e);
        end
        fall_seq("en_throttle_fall");

        // 6. Reset while qualifying with cnt=2, then a full restart with din still 1.
        seg("reset_mid", 1'b1, 1'b1, 2, 4'b0000);
        seg("reset_mid", 1'b1, 1'b1, 3, 4'b0001);
        seg("reset_mid", 1'b0, 1'b1, 1, 4'b0000);
        rise_seq("reset_mid_restart");

        // Let the monitor drain the last queued response.
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 5'(sb.size()), 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
